// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of the shared 16-bit ALU: accept, one EXEC cycle, held response.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [1:0]       alu_flags,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic [1:0]       resp_flags
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             id_q, id_d;
    logic             resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic [1:0]       resp_flags_q, resp_flags_d;
    logic             prio0, grant0, grant1, accept;

    // eq only reports through the zero flag, so its data result is discarded.
    function automatic logic [WIDTH-1:0] mask_result(input logic [1:0] op, input logic [WIDTH-1:0] r);
        return (op == 2'b10) ? '0 : r;
    endfunction

    function automatic logic [1:0] mask_flags(input logic [1:0] op, input logic [1:0] f);
        return {(op == 2'b00) & f[1], (op != 2'b01) & f[0]};
    endfunction

`ifdef ALU_ARB_RR_EN
    logic last_q, last_d;

    // Pointer starts at 1 so requester 0 wins the first contested grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (accept) last_d = grant1;
    end

    assign prio0 = last_q;
`else
    assign prio0 = 1'b1;
`endif

    assign grant0 = req0_valid && (!req1_valid || prio0);
    assign grant1 = req1_valid && !grant0;
    assign accept = req0_ready || req1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            id_q          <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            id_q          <= id_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_flags_q  <= resp_flags_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        id_d          = id_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_flags_d  = resp_flags_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = EXEC;
                op_d    = grant1 ? req1_op : req0_op;
                a_d     = grant1 ? req1_a  : req0_a;
                b_d     = grant1 ? req1_b  : req0_b;
                id_d    = grant1;
            end
            EXEC: begin
                state_d       = RESP;
                resp_id_d     = id_q;
                resp_result_d = mask_result(op_q, alu_result);
                resp_flags_d  = mask_flags(op_q, alu_flags);
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = !rst && (state_q == IDLE) && grant0;
        req1_ready = !rst && (state_q == IDLE) && grant1;
        resp_valid = (state_q == RESP);
    end

    assign alu_op      = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_flags  = resp_flags_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit ALU between two requesters (requester 0: execute-stage arithmetic, requester 1: memory address generation). It arbitrates, registers the winning operands, drives the ALU for one full cycle, and captures result and flags. It returns them on one response channel tagged with the requester id. It sits between the core's issue logic and the ALU instance.

## Interface
- WIDTH, 16, operand/result width; must equal ALU data width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op / req1_op  in  2  ALU op: 00 add_a, 01 nand, 10 eq, 11 add_m
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- alu_op  out  2  to ALU
- alu_a, alu_b  out  WIDTH  to ALU
- alu_result  in  WIDTH  from ALU
- alu_flags  in  2  from ALU; bit1 carry, bit0 zero
- resp_valid  out  1  response held
- resp_ready  in  1  consumer takes response
- resp_id  out  1  requester that issued the op
- resp_result  out  WIDTH  captured result
- resp_flags  out  2  captured, masked flags; bit1 carry, bit0 zero

## Operation
- FSM with three states: IDLE, EXEC, RESP.
- IDLE: arbitrate among valid requests. Assert req_ready only to the winner, combinationally, and only in IDLE. On accept, register op, operands and id, then go to EXEC.
- EXEC: exactly one cycle. alu_op/alu_a/alu_b come from registers and are stable for the whole cycle. At the closing edge:
  - capture alu_result/alu_flags into resp_*
  - go to RESP
- RESP: resp_valid=1; resp_* are held constant. When resp_valid&resp_ready, go to IDLE. resp_ready is ignored outside RESP.
- Result masking:
  - op 10 (eq): resp_result forced to 0; the ALU result is don't-care.
  - op 00 and 11: resp_result = alu_result.
  - op 01: resp_result = alu_result.
- Flag masking:
  - carry = alu_flags[1] only for op 00, else 0.
  - zero = alu_flags[0] for ops 00, 10 and 11; 0 for op 01.
- Arbitration: see Configuration. With a single valid request, that request always wins.
- A requester must hold valid and operands stable until accepted. A request that is not accepted is not dropped.
- alu_op/alu_a/alu_b keep their last registered value outside EXEC.

## Timing
- Reset values: state=IDLE; req*_ready=0 while rst is high; resp_valid=0; resp_id=0; resp_result=0; resp_flags=0; alu_op=0; alu_a=0; alu_b=0; round-robin pointer set so requester 0 wins first.
- Accept at edge T. The ALU is driven during cycle T..T+1. resp_valid rises after edge T+1.
- Minimum 3 cycles per operation: accept, EXEC, RESP with resp_ready already high. The next accept is possible in the cycle after RESP exits.
- resp_ready held low keeps the block in RESP indefinitely. Both req_ready stay 0 during this time.
- Reset asserted mid-operation (EXEC or RESP) discards the in-flight op. No response is issued. All outputs return to reset values asynchronously.
- Simultaneous req0_valid and req1_valid in IDLE: exactly one req_ready is asserted.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant pointer updates on each accept.
  - On simultaneous requests, the requester not granted last wins.
- ALU_ARB_RR_EN undefined: fixed priority.
  - Requester 0 always wins simultaneous requests.
  - No pointer register exists.

## Test plan
- Reset, then req0 op=00, a=16'hFFFF, b=16'h0001 accepted at T -> resp_valid after T+1; resp_id=0, resp_result=16'h0000, resp_flags=2'b11.
- req1 op=10, a=b=16'h1234 -> resp_id=1, resp_result=16'h0000, resp_flags=2'b01. Repeat with b=16'h1235 -> resp_flags=2'b00.
- req0 op=01, a=16'hFFFF, b=16'hFFFF -> resp_result=16'h0000, resp_flags=2'b00 (zero masked).
- Both requesters valid continuously, resp_ready=1:
  - with ALU_ARB_RR_EN, resp_id sequence is 0,1,0,1.
  - without it, the sequence is 0,0,0,0 and req1_ready never asserts.
- Hold resp_ready=0 for 5 cycles after a response -> resp_* stable and both req_ready=0. Raise resp_ready -> IDLE next cycle.
- Assert rst during EXEC of req1 op=11, a=16'h0010, b=16'h0004 -> no response; all outputs 0. After release, the first simultaneous-request grant goes to requester 0.
